// File: rtl/regfile_write_arbiter.sv
// Round-robin arbiter for the single register-file write port.
// Pair requests are issued as two beats, low byte then high byte, and cannot be split.
module regfile_write_arbiter #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  hold,
  input  logic                  req0,
  input  logic                  req1,
  input  logic                  pair0,
  input  logic                  pair1,
  input  logic [ADDR_W-1:0]     addr0,
  input  logic [ADDR_W-1:0]     addr1,
  input  logic [2*DATA_W-1:0]   data0,
  input  logic [2*DATA_W-1:0]   data1,
  output logic                  gnt0,
  output logic                  gnt1,
  output logic                  rf_en,
  output logic                  rf_wr,
  output logic [ADDR_W-1:0]     rf_waddr,
  output logic [DATA_W-1:0]     rf_wdata,
  input  logic [ADDR_W-1:0]     chk_addr1,
  input  logic [ADDR_W-1:0]     chk_addr2,
  output logic                  hazard1,
  output logic                  hazard2
);

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_WR_HI = 1'b1
  } state_t;

  state_t              state_r, state_nxt_s;
  logic                last_r, last_nxt_s;
  logic [ADDR_W-1:0]   hi_addr_r, hi_addr_nxt_s;
  logic [DATA_W-1:0]   hi_data_r, hi_data_nxt_s;
  logic                rf_en_r, rf_wr_r, en_nxt_s;
  logic [ADDR_W-1:0]   rf_waddr_r, waddr_nxt_s;
  logic [DATA_W-1:0]   rf_wdata_r, wdata_nxt_s;
  logic                gnt0_s, gnt1_s;
  logic                win_pair_s;
  logic [ADDR_W-1:0]   win_addr_s;
  logic [2*DATA_W-1:0] win_data_s;

  // Register following addr; the high byte of a pair at register 15 lands in register 0.
  function automatic logic [ADDR_W-1:0] pair_hi_addr(input logic [ADDR_W-1:0] a);
    return a + {{(ADDR_W-1){1'b0}}, 1'b1};
  endfunction

  function automatic logic addr_hazard(
    input logic [ADDR_W-1:0] chk,
    input logic              beat_en,
    input logic [ADDR_W-1:0] beat_addr,
    input logic              in_hi,
    input logic [ADDR_W-1:0] hi_addr,
    input logic              r0,
    input logic              p0,
    input logic [ADDR_W-1:0] a0,
    input logic              r1,
    input logic              p1,
    input logic [ADDR_W-1:0] a1
  );
    logic hit;
    hit = 1'b0;
    if (beat_en && (beat_addr == chk)) hit = 1'b1;
    if (in_hi && (hi_addr == chk)) hit = 1'b1;
    if (r0 && ((a0 == chk) || (p0 && (pair_hi_addr(a0) == chk)))) hit = 1'b1;
    if (r1 && ((a1 == chk) || (p1 && (pair_hi_addr(a1) == chk)))) hit = 1'b1;
    return hit;
  endfunction

  // Grant decision: only in IDLE without hold; a tie goes to the port that did not win last.
  always_comb begin
    gnt0_s = 1'b0;
    gnt1_s = 1'b0;
    if (rst_n && (state_r == ST_IDLE) && !hold) begin
      if (req0 && (!req1 || last_r)) begin
        gnt0_s = 1'b1;
      end else begin
        gnt0_s = 1'b0;
      end
      if (req1 && (!req0 || !last_r)) begin
        gnt1_s = 1'b1;
      end else begin
        gnt1_s = 1'b0;
      end
    end else begin
      gnt0_s = 1'b0;
      gnt1_s = 1'b0;
    end
  end

  // Winner operand mux.
  always_comb begin
    win_addr_s = addr0;
    win_data_s = data0;
    win_pair_s = pair0;
    if (gnt1_s) begin
      win_addr_s = addr1;
      win_data_s = data1;
      win_pair_s = pair1;
    end else begin
      win_addr_s = addr0;
      win_data_s = data0;
      win_pair_s = pair0;
    end
  end

  // Next-state and next-beat logic; address/data hold their value when no beat is issued.
  always_comb begin
    state_nxt_s   = state_r;
    last_nxt_s    = last_r;
    hi_addr_nxt_s = hi_addr_r;
    hi_data_nxt_s = hi_data_r;
    en_nxt_s      = 1'b0;
    waddr_nxt_s   = rf_waddr_r;
    wdata_nxt_s   = rf_wdata_r;
    case (state_r)
      ST_IDLE: begin
        if (gnt0_s || gnt1_s) begin
          en_nxt_s    = 1'b1;
          waddr_nxt_s = win_addr_s;
          wdata_nxt_s = win_data_s[DATA_W-1:0];
          last_nxt_s  = gnt1_s;
          if (win_pair_s) begin
            hi_addr_nxt_s = pair_hi_addr(win_addr_s);
            hi_data_nxt_s = win_data_s[2*DATA_W-1:DATA_W];
            state_nxt_s   = ST_WR_HI;
          end else begin
            state_nxt_s = ST_IDLE;
          end
        end else begin
          en_nxt_s    = 1'b0;
          state_nxt_s = ST_IDLE;
        end
      end
      ST_WR_HI: begin
        en_nxt_s    = 1'b1;
        waddr_nxt_s = hi_addr_r;
        wdata_nxt_s = hi_data_r;
        state_nxt_s = ST_IDLE;
      end
      default: begin
        en_nxt_s    = 1'b0;
        state_nxt_s = ST_IDLE;
      end
    endcase
  end

  // State and output registers; last resets to 1 so port 0 wins the first tie.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r    <= ST_IDLE;
      last_r     <= 1'b1;
      hi_addr_r  <= {ADDR_W{1'b0}};
      hi_data_r  <= {DATA_W{1'b0}};
      rf_en_r    <= 1'b0;
      rf_wr_r    <= 1'b0;
      rf_waddr_r <= {ADDR_W{1'b0}};
      rf_wdata_r <= {DATA_W{1'b0}};
    end else begin
      state_r    <= state_nxt_s;
      last_r     <= last_nxt_s;
      hi_addr_r  <= hi_addr_nxt_s;
      hi_data_r  <= hi_data_nxt_s;
      rf_en_r    <= en_nxt_s;
      rf_wr_r    <= en_nxt_s;
      rf_waddr_r <= waddr_nxt_s;
      rf_wdata_r <= wdata_nxt_s;
    end
  end

  // Read-after-write hazards against the beat on the port, a pending high beat and waiting requests.
  always_comb begin
    hazard1 = addr_hazard(chk_addr1, rf_en_r, rf_waddr_r, (state_r == ST_WR_HI), hi_addr_r,
                          req0, pair0, addr0, req1, pair1, addr1);
    hazard2 = addr_hazard(chk_addr2, rf_en_r, rf_waddr_r, (state_r == ST_WR_HI), hi_addr_r,
                          req0, pair0, addr0, req1, pair1, addr1);
  end

  assign gnt0     = gnt0_s;
  assign gnt1     = gnt1_s;
  assign rf_en    = rf_en_r;
  assign rf_wr    = rf_wr_r;
  assign rf_waddr = rf_waddr_r;
  assign rf_wdata = rf_wdata_r;

endmodule

// File: doc/regfile_write_arbiter.md
# regfile_write_arbiter

- Shares the single write port of the 8-bit MCU's 16x8 register file between two requesters: port 0 is ALU writeback and port 1 is load/pop data.
- Arbitrates round-robin and sequences atomic two-byte (register-pair) writes as consecutive beats.
- Drives the register file's EN/WR/Write_Addr/Write_Data from registered outputs.
- Reports combinational write hazards for the two read addresses so the decoder can stall.

## Interface
Parameters:
- ADDR_W, 4, register address width (16 registers)
- DATA_W, 8, register data width

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- hold  in  1  pipeline stall; blocks new grants while high
- req0, req1  in  1  write request, held stable until granted
- pair0, pair1  in  1  qualifies request as two-byte write
- addr0, addr1  in  ADDR_W  target register (low byte for pairs)
- data0, data1  in  2*DATA_W  [7:0] single/low byte, [15:8] high byte (pairs only)
- gnt0, gnt1  out  1  combinational accept pulse; request is consumed at this cycle's edge
- rf_en, rf_wr  out  1  register file enable/write, registered
- rf_waddr  out  ADDR_W  register file write address, registered
- rf_wdata  out  DATA_W  register file write data, registered
- chk_addr1, chk_addr2  in  ADDR_W  read addresses to check
- hazard1, hazard2  out  1  combinational: a pending or in-flight write targets chk_addrN

## Operation
- FSM states:
  - IDLE: may accept a request.
  - WR_HI: issues the high beat of an accepted pair; grants nothing.
- IDLE, hold=0, any req:
  - Select by round-robin pointer `last`. If only one requester is active, it wins. If both are active, the requester not equal to `last` wins.
  - Assert gnt of the winner only; set last=winner at the edge.
- Accept edge:
  - rf_en=rf_wr=1, rf_waddr=addr, rf_wdata=data[7:0].
  - If pair=1: latch hi_addr=(addr+1) mod 16 (15 wraps to 0) and hi_data=data[15:8], then go to WR_HI.
- WR_HI edge: rf_en=rf_wr=1, rf_waddr=hi_addr, rf_wdata=hi_data; go to IDLE. hold is ignored (pair is atomic).
- No accept (IDLE with no req, or hold=1): rf_en=rf_wr=0; rf_waddr/rf_wdata keep their last value.
- Requester must drop or change req in the cycle after gnt. A still-high req is treated as a new request.
- hazardN=1 when chk_addrN matches any of:
  - rf_waddr while rf_en=1
  - hi_addr while in WR_HI
  - addrK for active reqK
  - (addrK+1) mod 16 for active reqK with pairK=1
- Same address from both requesters: writes are serialized in grant order, so the later grant's data survives.

## Timing
- Reset (async, rst_n=0), values:
  - rf_en=0, rf_wr=0, rf_waddr=0, rf_wdata=0
  - state=IDLE, last=1 (so port 0 wins the first tie)
  - hi_addr=0, hi_data=0
  - gnt0=gnt1=0 regardless of req
- Single write: gnt in cycle k; rf_* beat valid in cycle k+1; register file commits at end of k+1.
- Pair write: gnt in cycle k; low beat in k+1, high beat in k+2. The next grant is possible no earlier than cycle k+2, with its beat in k+3.
- Throughput: one single write per cycle. Back-to-back singles from one requester are allowed.
- Fairness bound: with both requesting singles continuously, grants alternate. A held request is granted within 3 cycles when hold=0.
- Reset asserted during WR_HI: high beat is discarded; outputs return to reset values immediately.
- hold rising in the same cycle as req: no grant; rf_en=0 next cycle.

## Test plan
- Reset then single write:
  - Stimulus: req0=1, addr0=4'h3, data0=16'h00A5.
  - Response: gnt0=1 for 1 cycle; next cycle rf_en=rf_wr=1, rf_waddr=3, rf_wdata=A5; cycle after, rf_en=0.
- Simultaneous singles:
  - Stimulus: req0 (addr0=0, data=FF) and req1 (addr1=1, data=F7) held together.
  - Response: gnt0 then gnt1 in consecutive cycles; beats to addresses 0 then 1 with data FF then F7; a read-back of both registers matches.
- Pair with wrap:
  - Stimulus: req1=1, pair1=1, addr1=4'hF, data1=16'h1234.
  - Response: beats (F,34) then (0,12); req0 raised during WR_HI receives no grant until the following cycle.
- hold:
  - Stimulus: hold=1 for 3 cycles with req0 active.
  - Response: no gnt, rf_en=0 throughout; gnt0 in the first cycle after hold falls.
- Hazard:
  - Stimulus: req0 pending with pair0=1, addr0=6; chk_addr1=7, chk_addr2=8.
  - Response: hazard1=1, hazard2=0; after the high beat retires, hazard1=0.
- Reset mid-pair:
  - Stimulus: rst_n low in the WR_HI cycle.
  - Response: rf_en=0 and rf_waddr=0 immediately; no high beat issued; first tie after reset is granted to port 0.
